// File: rtl/data_mem_pkg.sv
// Shared constants and enums for the data-memory arbiter and its video fetcher.
package data_mem_pkg;
  localparam int SCREEN_BASE  = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int KB_ADR       = 24576;
  localparam int WC_W         = 13;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_VID} grant_e;
endpackage

// File: rtl/vid_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head reads as 0 while empty.
module vid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_underflow;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_count     = r_count;
  assign o_underflow = r_underflow;
  assign o_head      = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= i_pop && o_empty;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the data memory port between the CPU and the video scan-out fetcher.
// Optional keyboard-map write protect: define DATA_MEM_ARB_KB_WP_EN.
module data_mem_arbiter #(
  parameter int FIFO_DEPTH     = 8,
  parameter int LOW_WM         = 2,
  parameter int MAX_CPU_STREAK = 4,
  parameter int SCREEN_BASE    = data_mem_pkg::SCREEN_BASE,
  parameter int SCREEN_WORDS   = data_mem_pkg::SCREEN_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_adr,
  input  logic [15:0] cpu_d_in,
  output logic [15:0] cpu_d_out,
  output logic        cpu_ready,
  input  logic        vid_start,
  input  logic        vid_pop,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic        vid_underflow,
  output logic        vid_frame_done,
  output logic        mem_load,
  output logic [14:0] mem_adr,
  output logic [15:0] mem_d_in,
  input  logic [15:0] mem_d_out
`ifdef DATA_MEM_ARB_KB_WP_EN
  ,
  output logic        kb_wp_err
`endif
);
  import data_mem_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(MAX_CPU_STREAK + 1);

  fetch_state_e    r_state, w_state_next;
  logic [WC_W-1:0] r_wc, w_wc_next;
  logic [SW-1:0]   r_streak, w_streak_next;
  logic            r_frame_done, w_frame_done_next;
  grant_e          w_grant;
  logic            w_vid_want, w_urgent, w_cpu_blocked, w_kb_hit;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full, w_fifo_empty;
  logic [14:0]     w_vid_adr;

  vid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (vid_start),
    .i_push      (w_grant == GNT_VID),
    .i_push_data (mem_d_out),
    .i_pop       (vid_pop),
    .o_head      (vid_data),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_underflow (vid_underflow)
  );

  assign vid_valid      = !w_fifo_empty;
  assign vid_frame_done = r_frame_done;
  assign w_vid_adr      = 15'(SCREEN_BASE) + 15'(r_wc);
  assign w_vid_want     = (r_state == FETCH) && !w_fifo_full;
  assign w_urgent       = w_vid_want && (w_fifo_count <= CW'(LOW_WM));
  assign w_cpu_blocked  = w_urgent || (w_vid_want && (r_streak >= SW'(MAX_CPU_STREAK)));

`ifdef DATA_MEM_ARB_KB_WP_EN
  assign w_kb_hit  = cpu_we && (cpu_adr == 15'(KB_ADR));
  assign kb_wp_err = (w_grant == GNT_CPU) && w_kb_hit;
`else
  assign w_kb_hit  = 1'b0;
`endif

  always_comb begin
    w_grant = GNT_NONE;
    if (cpu_req && !w_cpu_blocked) w_grant = GNT_CPU;
    else if (w_vid_want)           w_grant = GNT_VID;
    else if (cpu_req)              w_grant = GNT_CPU;
  end

  always_comb begin
    mem_load  = 1'b0;
    mem_adr   = '0;
    mem_d_in  = cpu_d_in;
    cpu_ready = 1'b0;
    cpu_d_out = '0;
    case (w_grant)
      GNT_CPU: begin
        mem_adr   = cpu_adr;
        mem_load  = cpu_we && !w_kb_hit;
        cpu_ready = 1'b1;
        cpu_d_out = mem_d_out;
      end
      GNT_VID: mem_adr = w_vid_adr;
      default: ;
    endcase
  end

  // A frame-start pulse overrides any same-cycle fetch bookkeeping.
  always_comb begin
    w_state_next      = r_state;
    w_wc_next         = r_wc;
    w_frame_done_next = 1'b0;
    if (vid_start) begin
      w_state_next = FETCH;
      w_wc_next    = '0;
    end else if (w_grant == GNT_VID) begin
      w_wc_next = r_wc + WC_W'(1);
      if (r_wc == WC_W'(SCREEN_WORDS - 1)) begin
        w_state_next      = DONE;
        w_frame_done_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_streak_next = r_streak;
    if (!w_vid_want || (w_grant == GNT_VID)) begin
      w_streak_next = '0;
    end else if ((w_grant == GNT_CPU) && (r_streak < SW'(MAX_CPU_STREAK))) begin
      w_streak_next = r_streak + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wc         <= '0;
      r_streak     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wc         <= w_wc_next;
      r_streak     <= w_streak_next;
      r_frame_done <= w_frame_done_next;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_data_mem_arbiter;
  localparam int FIFO_DEPTH     = 8;
  localparam int LOW_WM         = 2;
  localparam int MAX_CPU_STREAK = 4;
  localparam int SCREEN_BASE    = 16384;
  localparam int SCREEN_WORDS   = 8192;
  localparam int KB_ADR         = 24576;

  logic        clk = 1'b0;
  logic        reset, cpu_req, cpu_we, vid_start, vid_pop;
  logic [14:0] cpu_adr;
  logic [15:0] cpu_d_in, cpu_d_out, vid_data, mem_d_in, mem_d_out;
  logic        cpu_ready, vid_valid, vid_underflow, vid_frame_done, mem_load;
  logic [14:0] mem_adr;
`ifdef DATA_MEM_ARB_KB_WP_EN
  logic        kb_wp_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] tb_mem [32768];
  assign mem_d_out = tb_mem[mem_adr];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .FIFO_DEPTH(FIFO_DEPTH), .LOW_WM(LOW_WM), .MAX_CPU_STREAK(MAX_CPU_STREAK),
    .SCREEN_BASE(SCREEN_BASE), .SCREEN_WORDS(SCREEN_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .cpu_ready(cpu_ready),
    .vid_start(vid_start), .vid_pop(vid_pop), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_underflow(vid_underflow), .vid_frame_done(vid_frame_done),
    .mem_load(mem_load), .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
`ifdef DATA_MEM_ARB_KB_WP_EN
    , .kb_wp_err(kb_wp_err)
`endif
  );

  // Behavioural model: FIFO as a queue, fetch progress as plain integers.
  logic [15:0] m_q[$];
  bit          m_fetch;
  int          m_wc, m_streak;
  bit          m_uf, m_fd;
  bit          e_want, e_urgent, e_cpu_first, e_gcpu, e_gvid, e_load, e_valid, e_kb;
  logic [14:0] e_adr;
  logic [15:0] e_dout, e_data;

  task automatic calc_exp();
    e_want      = m_fetch && (m_q.size() < FIFO_DEPTH);
    e_urgent    = e_want && (m_q.size() <= LOW_WM);
    e_cpu_first = cpu_req && !e_urgent && !(e_want && m_streak >= MAX_CPU_STREAK);
    e_gcpu      = e_cpu_first || (cpu_req && !e_want);
    e_gvid      = !e_cpu_first && e_want;
    e_adr       = e_gcpu ? cpu_adr : (e_gvid ? 15'(SCREEN_BASE + m_wc) : 15'd0);
`ifdef DATA_MEM_ARB_KB_WP_EN
    e_kb        = e_gcpu && cpu_we && (int'(cpu_adr) == KB_ADR);
`else
    e_kb        = 1'b0;
`endif
    e_load      = e_gcpu && cpu_we && !e_kb;
    e_dout      = e_gcpu ? tb_mem[cpu_adr] : 16'd0;
    e_valid     = (m_q.size() > 0);
    e_data      = (m_q.size() > 0) ? m_q[0] : 16'd0;
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) tb_mem[a] = 16'($urandom);
    m_fetch = 0; m_wc = 0; m_streak = 0; m_uf = 0; m_fd = 0;
    forever begin
      @(posedge clk);
      calc_exp();
      if (reset) begin
        m_q.delete(); m_fetch = 0; m_wc = 0; m_streak = 0; m_uf = 0; m_fd = 0;
      end else begin
        m_uf = vid_pop && (m_q.size() == 0);
        m_fd = 0;
        if (vid_start) begin
          m_q.delete(); m_wc = 0; m_fetch = 1;
        end else begin
          if (vid_pop && m_q.size() > 0) void'(m_q.pop_front());
          if (e_gvid) begin
            m_q.push_back(tb_mem[SCREEN_BASE + m_wc]);
            if (m_wc == SCREEN_WORDS - 1) begin
              m_fetch = 0; m_fd = 1;
            end
            m_wc++;
          end
        end
        if (!e_want || e_gvid) m_streak = 0;
        else if (e_gcpu && m_streak < MAX_CPU_STREAK) m_streak++;
      end
      if (mem_load) tb_mem[mem_adr] <= mem_d_in;
    end
  end

  task automatic drive(input logic req, input logic we, input logic [14:0] adr,
                       input logic [15:0] din, input logic start, input logic pop);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = req; cpu_we = we; cpu_adr = adr; cpu_d_in = din;
    vid_start = start; vid_pop = pop;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_d_in = '0; vid_start = 0; vid_pop = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks += 4;
    if (vid_valid !== 1'b0 || vid_data !== 16'd0) begin
      n_errors++; $display("FAIL reset_fifo valid=%b data=%h expected 0/0000", vid_valid, vid_data);
    end
    if (vid_underflow !== 1'b0 || vid_frame_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_pulses uf=%b fd=%b expected 0/0", vid_underflow, vid_frame_done);
    end
    if (mem_adr !== 15'd0 || mem_load !== 1'b0) begin
      n_errors++; $display("FAIL reset_mem adr=%0d load=%b expected 0/0", mem_adr, mem_load);
    end
    if (cpu_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready got=%b expected 0", cpu_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_cpu_rw();
    drive(1, 1, 15'd100, 16'h1234, 0, 0);
    settle();
    n_checks += 2;
    if (cpu_ready !== 1'b1) begin
      n_errors++; $display("FAIL cpu_write_ready got=%b expected 1", cpu_ready);
    end
    if (mem_load !== 1'b1 || mem_adr !== 15'd100 || mem_d_in !== 16'h1234) begin
      n_errors++; $display("FAIL cpu_write_mem load=%b adr=%0d din=%h expected 1/100/1234", mem_load, mem_adr, mem_d_in);
    end
    drive(1, 0, 15'd100, 16'h0000, 0, 0);
    settle();
    n_checks += 3;
    if (cpu_ready !== 1'b1) begin
      n_errors++; $display("FAIL cpu_read_ready got=%b expected 1", cpu_ready);
    end
    if (cpu_d_out !== 16'h1234) begin
      n_errors++; $display("FAIL cpu_read_data got=%h expected 1234", cpu_d_out);
    end
    if (vid_valid !== 1'b0) begin
      n_errors++; $display("FAIL cpu_rw_vid_valid got=%b expected 0", vid_valid);
    end
    $display("test_cpu_rw done");
  endtask

  task automatic test_frame();
    int done_pulses = 0;
    drive(0, 0, '0, '0, 1, 0);
    for (int j = 0; j < SCREEN_WORDS + 8; j++) begin
      drive(0, 0, '0, '0, 0, 1);
      settle();
      n_checks += 3;
      if (j < SCREEN_WORDS) begin
        if (mem_adr !== 15'(SCREEN_BASE + j) || mem_load !== 1'b0) begin
          n_errors++; $display("FAIL frame_fetch_adr j=%0d got=%0d load=%b expected %0d/0", j, mem_adr, mem_load, SCREEN_BASE + j);
        end
      end else if (mem_adr !== 15'd0) begin
        n_errors++; $display("FAIL frame_after_done_adr j=%0d got=%0d expected 0", j, mem_adr);
      end
      if (vid_valid !== (j >= 1 && j <= SCREEN_WORDS)) begin
        n_errors++; $display("FAIL frame_valid j=%0d got=%b", j, vid_valid);
      end else if (j >= 1 && j <= SCREEN_WORDS && vid_data !== tb_mem[SCREEN_BASE + j - 1]) begin
        n_errors++; $display("FAIL frame_data j=%0d got=%h expected %h", j, vid_data, tb_mem[SCREEN_BASE + j - 1]);
      end
      if (vid_frame_done !== (j == SCREEN_WORDS)) begin
        n_errors++; $display("FAIL frame_done_timing j=%0d got=%b", j, vid_frame_done);
      end
      if (vid_frame_done === 1'b1) done_pulses++;
    end
    n_checks++;
    if (done_pulses != 1) begin
      n_errors++; $display("FAIL frame_done_count got=%0d expected 1", done_pulses);
    end
    drive(0, 0, '0, '0, 0, 0);
    $display("test_frame done");
  endtask

  task automatic test_cpu_streak();
    drive(0, 0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, '0, '0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 15'(300 + k), '0, 0, 0);
      settle();
      n_checks++;
      if (cpu_ready !== ((k % 5) != 4)) begin
        n_errors++; $display("FAIL streak_ready k=%0d got=%b expected %b", k, cpu_ready, (k % 5) != 4);
      end
    end
    drive(0, 0, '0, '0, 0, 0);
    $display("test_cpu_streak done");
  endtask

  task automatic test_urgent();
    drive(0, 0, '0, '0, 1, 0);
    drive(0, 0, '0, '0, 0, 0);
    drive(0, 0, '0, '0, 0, 0);
    drive(1, 1, 15'd200, 16'hBEEF, 0, 0);
    settle();
    n_checks += 2;
    if (cpu_ready !== 1'b0 || mem_load !== 1'b0) begin
      n_errors++; $display("FAIL urgent_cpu_stall ready=%b load=%b expected 0/0", cpu_ready, mem_load);
    end
    if (mem_adr !== 15'(SCREEN_BASE + 2)) begin
      n_errors++; $display("FAIL urgent_vid_adr got=%0d expected %0d", mem_adr, SCREEN_BASE + 2);
    end
    drive(1, 1, 15'd200, 16'hBEEF, 0, 0);
    settle();
    n_checks++;
    if (cpu_ready !== 1'b1 || mem_adr !== 15'd200 || mem_load !== 1'b1) begin
      n_errors++; $display("FAIL above_wm_cpu ready=%b adr=%0d load=%b expected 1/200/1", cpu_ready, mem_adr, mem_load);
    end
    drive(0, 0, '0, '0, 0, 0);
    $display("test_urgent done");
  endtask

  task automatic test_underflow_restart();
    do_reset();
    drive(0, 0, '0, '0, 0, 1);
    drive(0, 0, '0, '0, 0, 0);
    settle();
    n_checks++;
    if (vid_underflow !== 1'b1 || vid_valid !== 1'b0) begin
      n_errors++; $display("FAIL underflow_pulse uf=%b valid=%b expected 1/0", vid_underflow, vid_valid);
    end
    drive(0, 0, '0, '0, 0, 0);
    settle();
    n_checks++;
    if (vid_underflow !== 1'b0) begin
      n_errors++; $display("FAIL underflow_width got=%b expected 0", vid_underflow);
    end
    drive(0, 0, '0, '0, 1, 0);
    for (int j = 0; j < 500; j++) drive(0, 0, '0, '0, 0, 1);
    drive(0, 0, '0, '0, 1, 0);
    settle();
    n_checks++;
    if (mem_adr !== 15'(SCREEN_BASE + 500)) begin
      n_errors++; $display("FAIL restart_wc500_adr got=%0d expected %0d", mem_adr, SCREEN_BASE + 500);
    end
    drive(0, 0, '0, '0, 0, 0);
    settle();
    n_checks++;
    if (vid_valid !== 1'b0 || mem_adr !== 15'(SCREEN_BASE)) begin
      n_errors++; $display("FAIL restart_flush valid=%b adr=%0d expected 0/%0d", vid_valid, mem_adr, SCREEN_BASE);
    end
    drive(0, 0, '0, '0, 0, 0);
    settle();
    n_checks++;
    if (vid_valid !== 1'b1 || vid_data !== tb_mem[SCREEN_BASE]) begin
      n_errors++; $display("FAIL restart_first_word valid=%b data=%h expected 1/%h", vid_valid, vid_data, tb_mem[SCREEN_BASE]);
    end
    $display("test_underflow_restart done");
  endtask

  task automatic test_reset_midframe();
    drive(0, 0, '0, '0, 1, 0);
    for (int j = 0; j < 5; j++) drive(0, 0, '0, '0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, '0, '0, 0, 0);
      settle();
      n_checks++;
      if (mem_adr !== 15'd0 || vid_valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_abort j=%0d adr=%0d valid=%b expected 0/0", j, mem_adr, vid_valid);
      end
    end
    $display("test_reset_midframe done");
  endtask

`ifdef DATA_MEM_ARB_KB_WP_EN
  task automatic test_kb_wp();
    logic [15:0] before;
    do_reset();
    before = tb_mem[KB_ADR];
    drive(1, 1, 15'(KB_ADR), 16'hFFFF, 0, 0);
    settle();
    n_checks++;
    if (mem_load !== 1'b0 || kb_wp_err !== 1'b1 || cpu_ready !== 1'b1) begin
      n_errors++; $display("FAIL kb_wp load=%b err=%b ready=%b expected 0/1/1", mem_load, kb_wp_err, cpu_ready);
    end
    drive(0, 0, '0, '0, 0, 0);
    settle();
    n_checks += 2;
    if (kb_wp_err !== 1'b0) begin
      n_errors++; $display("FAIL kb_wp_width got=%b expected 0", kb_wp_err);
    end
    if (tb_mem[KB_ADR] !== before) begin
      n_errors++; $display("FAIL kb_wp_mem got=%h expected %h", tb_mem[KB_ADR], before);
    end
    $display("test_kb_wp done");
  endtask
`endif

  task automatic test_random();
    logic        req, we, start, pop;
    logic [14:0] adr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 9) < 7);
      we    = 1'($urandom_range(0, 1));
      adr   = ($urandom_range(0, 3) == 0) ? 15'(SCREEN_BASE + $urandom_range(0, SCREEN_WORDS - 1))
            : ($urandom_range(0, 49) == 0) ? 15'(KB_ADR) : 15'($urandom);
      start = (i == 0) || ($urandom_range(0, 799) == 0);
      pop   = !start && ((((i / 400) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      drive(req, we, adr, 16'($urandom), start, pop);
      settle();
      calc_exp();
      n_checks += 7;
      if (cpu_ready !== e_gcpu) begin
        n_errors++; $display("FAIL rnd_ready i=%0d got=%b expected %b", i, cpu_ready, e_gcpu);
      end
      if (mem_adr !== e_adr || mem_load !== e_load) begin
        n_errors++; $display("FAIL rnd_mem i=%0d adr=%0d load=%b expected %0d/%b", i, mem_adr, mem_load, e_adr, e_load);
      end
      if (e_load && mem_d_in !== cpu_d_in) begin
        n_errors++; $display("FAIL rnd_din i=%0d got=%h expected %h", i, mem_d_in, cpu_d_in);
      end
      if (cpu_d_out !== e_dout) begin
        n_errors++; $display("FAIL rnd_dout i=%0d got=%h expected %h", i, cpu_d_out, e_dout);
      end
      if (vid_valid !== e_valid || vid_data !== e_data) begin
        n_errors++; $display("FAIL rnd_vid i=%0d valid=%b data=%h expected %b/%h", i, vid_valid, vid_data, e_valid, e_data);
      end
      if (vid_underflow !== m_uf) begin
        n_errors++; $display("FAIL rnd_underflow i=%0d got=%b expected %b", i, vid_underflow, m_uf);
      end
      if (vid_frame_done !== m_fd) begin
        n_errors++; $display("FAIL rnd_frame_done i=%0d got=%b expected %b", i, vid_frame_done, m_fd);
      end
`ifdef DATA_MEM_ARB_KB_WP_EN
      n_checks++;
      if (kb_wp_err !== e_kb) begin
        n_errors++; $display("FAIL rnd_kb i=%0d got=%b expected %b", i, kb_wp_err, e_kb);
      end
`endif
    end
    drive(0, 0, '0, '0, 0, 0);
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_d_in = '0; vid_start = 0; vid_pop = 0;
    test_reset();
    test_cpu_rw();
    test_frame();
    test_cpu_streak();
    test_urgent();
    test_underflow_restart();
    test_reset_midframe();
`ifdef DATA_MEM_ARB_KB_WP_EN
    test_kb_wp();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
